// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT post-processing stages.
package fft_pkg;

    localparam int unsigned FFT_DATA_W   = 16;
    localparam int unsigned FFT_PWR_W    = 32;
    localparam int unsigned FFT_LOG2N    = 10;
    localparam int unsigned BITREV_MAX_W = 16;

    typedef enum logic {
        StIdle,
        StRun
    } pd_state_e;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                       input int unsigned             w);
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cplx_pwr.sv
// Two-stage registered |x|^2 = re^2 + im^2 with a valid bit travelling alongside.
module cplx_pwr
    import fft_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [FFT_DATA_W-1:0] re,
    input  logic signed [FFT_DATA_W-1:0] im,
    output logic                         out_valid,
    output logic [FFT_PWR_W-1:0]         pwr
);

    localparam int unsigned SqW = 2 * FFT_DATA_W - 1;

    logic signed [2*FFT_DATA_W-1:0] re_prod, im_prod;
    logic [SqW-1:0]                 re_sq_q, im_sq_q;
    logic                           v1_q, v2_q;
    logic [FFT_PWR_W-1:0]           pwr_q;

    // A square is never negative and peaks at 2^30, so the low 31 bits hold it exactly.
    assign re_prod = re * re;
    assign im_prod = im * im;

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            re_sq_q <= '0;
            im_sq_q <= '0;
            pwr_q   <= '0;
        end else begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            if (in_valid) begin
                re_sq_q <= re_prod[SqW-1:0];
                im_sq_q <= im_prod[SqW-1:0];
            end
            if (v1_q) begin
                pwr_q <= {1'b0, re_sq_q} + {1'b0, im_sq_q};
            end
        end
    end

    assign out_valid = v2_q;
    assign pwr       = pwr_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame spectral peak search over the FFT output stream.
// Define FFT_PEAK_BITREV_EN when the stream arrives in bit-reversed bin order.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N   = FFT_LOG2N,
    parameter bit          SKIP_DC = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic signed [FFT_DATA_W-1:0] Xb_re,
    input  logic signed [FFT_DATA_W-1:0] Xb_im,
    output logic                         peak_valid,
    output logic [LOG2N-1:0]             peak_idx,
    output logic [FFT_PWR_W-1:0]         peak_mag,
    output logic                         frame_err
);

    localparam logic [LOG2N-1:0] LastPos = '1;

    typedef struct packed {
        logic             start;
        logic             last;
        logic [LOG2N-1:0] bin;
    } tag_t;

    pd_state_e            state_q, state_d;
    logic [LOG2N-1:0]     pos_q, pos_d, cur_pos, bin;
    logic                 acc, err_d;
    tag_t                 tag_in, tag1_q, tag2_q;
    logic                 pwr_valid;
    logic [FFT_PWR_W-1:0] pwr;
    logic [FFT_PWR_W-1:0] max_q, base_max, new_max;
    logic [LOG2N-1:0]     idx_q, base_idx, new_idx;
    logic                 seed_q, base_seed, new_seed, eligible, take;

`ifdef FFT_PEAK_BITREV_EN
    assign bin = LOG2N'(bitrev(BITREV_MAX_W'(cur_pos), LOG2N));
`else
    assign bin = cur_pos;
`endif

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        acc     = 1'b0;
        err_d   = 1'b0;
        cur_pos = in_sof ? '0 : pos_q;
        if (in_valid) begin
            if (in_sof) begin
                acc     = 1'b1;
                state_d = StRun;
                err_d   = (state_q == StRun) && (pos_q != '0);
            end else if (state_q == StRun) begin
                acc = 1'b1;
            end
            if (acc) begin
                pos_d = cur_pos + 1'b1;
                if (cur_pos == LastPos) begin
                    state_d = StIdle;
                end
            end
        end
    end

    assign tag_in = '{start: in_sof, last: (cur_pos == LastPos), bin: bin};

    cplx_pwr u_cplx_pwr (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (acc),
        .re        (Xb_re),
        .im        (Xb_im),
        .out_valid (pwr_valid),
        .pwr       (pwr)
    );

    // A frame-start sample restarts the search, which also discards any aborted frame.
    always_comb begin
        base_max  = tag2_q.start ? '0 : max_q;
        base_idx  = tag2_q.start ? '0 : idx_q;
        base_seed = tag2_q.start ? 1'b0 : seed_q;
        eligible  = !(SKIP_DC && (tag2_q.bin == '0));
        take      = eligible && ((SKIP_DC && !base_seed) || (pwr > base_max));
        new_max   = take ? pwr : base_max;
        new_idx   = take ? tag2_q.bin : base_idx;
        new_seed  = base_seed | eligible;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            pos_q      <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            max_q      <= '0;
            idx_q      <= '0;
            seed_q     <= 1'b0;
            peak_valid <= 1'b0;
            peak_idx   <= '0;
            peak_mag   <= '0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            tag1_q     <= tag_in;
            tag2_q     <= tag1_q;
            frame_err  <= err_d;
            peak_valid <= 1'b0;
            if (pwr_valid) begin
                max_q  <= new_max;
                idx_q  <= new_idx;
                seed_q <= new_seed;
                if (tag2_q.last) begin
                    peak_valid <= 1'b1;
                    peak_idx   <= new_idx;
                    peak_mag   <= new_max;
                end
            end
        end
    end

endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Streaming spectral peak detector directly downstream of `FFT_top`. It consumes the 16-bit complex output stream `Xb_re`/`Xb_im` one bin per accepted cycle and computes |X|² for every bin. It tracks the maximum over each N-point frame and emits the winning bin index and power once per frame. It feeds the readout/control logic with a single peak report instead of a full 1024-bin dump.

## Interface
- `LOG2N`, 10: log2 of frame length; N = 2^LOG2N bins per frame.
- `SKIP_DC`, 1: when 1, bin 0 is excluded from the search.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  current `Xb_re`/`Xb_im` sample is valid and accepted.
- `in_sof`  in  1  start of frame; qualified by `in_valid`; marks stream position 0.
- `Xb_re`  in  16  signed real part of FFT output.
- `Xb_im`  in  16  signed imaginary part of FFT output.
- `peak_valid`  out  1  one-cycle pulse; peak outputs are valid for the frame just completed.
- `peak_idx`  out  LOG2N  bin index of the maximum.
- `peak_mag`  out  32  unsigned re²+im² of the maximum.
- `frame_err`  out  1  one-cycle pulse; the previous frame was truncated by an early `in_sof`.

## Operation
- Position counter `pos` (LOG2N bits) counts accepted samples. `in_valid & in_sof` forces position 0. Otherwise each `in_valid` advances `pos`; there is no wrap into a new frame without `in_sof`.
- Frame states:
  - IDLE: samples are ignored until `in_valid & in_sof`.
  - RUN: samples are accumulated.
  - At the accepted sample with pos = N-1, the block reports and returns to IDLE.
- Bin index: equals `pos`, or bitrev(`pos`) under the macro (see Configuration).
- Power pipeline:
  - Stage 1: register re² and im², each 31 bits unsigned.
  - Stage 2: register the 32-bit sum; compare it with the running maximum.
  - Maximum value: (-32768)²·2 = 2^31, so the sum fits in 32 bits with no saturation.
- Compare rule: update the running maximum only on strictly greater power, so ties keep the first-arriving bin.
  - Running max resets to 0 and its index to 0 at frame start.
  - If all bins are zero, the report is idx 0 (or 1 with `SKIP_DC=1`), mag 0.
- With `SKIP_DC=1`, bin index 0 never updates the maximum. The first non-DC bin seeds it.
- `in_valid` low: the pipeline stages hold their valid bits (bubbles propagate) and `pos` holds.
- `in_sof` while in RUN with pos ≠ 0:
  - the partial frame is discarded and no `peak_valid` is issued;
  - `frame_err` pulses once;
  - the new frame starts with this sample at position 0.
- `rst` low mid-frame: all state returns to IDLE and all outputs return to 0 on the next edge.

## Timing
- Reset values: `peak_valid`=0, `peak_idx`=0, `peak_mag`=0, `frame_err`=0, state IDLE, `pos`=0.
- Latency: the last-bin sample is accepted at edge k; `peak_valid` is high in the cycle after edge k+2 (pipeline depth 2, plus registered output).
- `peak_idx`/`peak_mag` hold their value until the next `peak_valid`.
- `frame_err` is registered. It asserts the cycle after the offending `in_sof` sample is accepted.
- Back-to-back frames with no gap (`in_sof` on the cycle after the last bin) are supported. The next frame's accumulation does not disturb the pending report.
- Throughput: one sample per cycle, with no backpressure.

## Configuration
- `FFT_PEAK_BITREV_EN`:
  - Defined: stream position p carries natural bin bitrev(p) over LOG2N bits. `peak_idx` and `SKIP_DC` use the natural index, and the tie rule still keeps the first-arriving bin.
  - Undefined: the stream is in natural order and the index equals `pos`.

## Structure
- Shared package `fft_pkg` holds:
  - `FFT_DATA_W`=16;
  - `FFT_PWR_W`=32;
  - the default `LOG2N`;
  - a `bitrev` function parameterised on width.
- One sub-module, `cplx_pwr`: a 2-stage registered re²+im² unit with a valid pass-through, reusable by other spectral stages.

## Test plan
- Tone at bin 10: re=1000 at pos 10, all other bins 0 → `peak_valid` once, idx 10, mag 1000000, 3 cycles after the last sample.
- Extreme input: re=im=-32768 at pos 5, all other bins 0 → mag 0x80000000, idx 5.
- Tie and DC: with `SKIP_DC=1`, bin 0 = 5000 and bins 3 and 7 = 100 → idx 3, mag 10000. With `SKIP_DC=0` → idx 0, mag 25000000.
- Early `in_sof` at pos 400, then a full frame with a tone at bin 20:
  - `frame_err` pulses once, with no report for the first frame;
  - next report is idx 20.
- `in_valid` gaps:
  - random 50% duty, tone at bin 77 → idx 77, with a report only after the 1024th accepted sample;
  - `rst` low mid-frame → all outputs 0 and no report.
- With `FFT_PEAK_BITREV_EN`, N=1024: tone at stream position 1 → `peak_idx` 512.
